// File: rtl/rx_status_sequencer.sv
// Rx frame sequencer: gates frame admission on free status slots, accumulates
// frame length, and queues late good/bad verdicts into a show-ahead FIFO.
module rx_status_sequencer #(
  parameter int DEPTH       = 4,
  parameter int AW          = 2,
  parameter int LEN_W       = 14,
  parameter int RES_TIMEOUT = 32
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic               cfg_rx_en,
  input  logic               receiving_frame,
  input  logic [3:0]         bytes_vld,
  input  logic               good_frame_get,
  input  logic               bad_frame_get,
  output logic               recv_enable,
  output logic               stat_valid,
  output logic [LEN_W+1:0]   stat_data,
  input  logic               stat_ack,
  output logic [AW:0]        stat_level,
  output logic [15:0]        good_cnt,
  output logic [15:0]        bad_cnt
);

  localparam int TW = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(RES_TIMEOUT - 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    DISABLED,
    ARMED,
    FRAME,
    WAIT_RES,
    POST
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [TW-1:0]     tcnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LEN_W+1:0]  mem [DEPTH];

  logic              verdict;
  logic              is_good;
  logic [LEN_W:0]    sum;
  logic [LEN_W-1:0]  len_sat;
  logic [LEN_W-1:0]  len_acc;
  logic              push;
  logic [LEN_W+1:0]  push_word;
  logic              pop;
  logic              full;

  assign verdict    = good_frame_get | bad_frame_get;
  assign is_good    = good_frame_get & ~bad_frame_get;
  assign stat_valid = (stat_level != '0);
  assign stat_data  = mem[rd_ptr];
  assign pop        = stat_valid & stat_ack;
  assign full       = (stat_level == FULL_LVL);

  always_comb begin
    sum       = {1'b0, len} + (LEN_W+1)'(bytes_vld);
    len_sat   = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    len_acc   = receiving_frame ? len_sat : len;
    push      = 1'b0;
    push_word = '0;
    unique case (state)
      FRAME: begin
        if (verdict) begin
          push      = 1'b1;
          push_word = {1'b0, is_good, len_acc};
        end
      end
      WAIT_RES: begin
        if (verdict) begin
          push      = 1'b1;
          push_word = {1'b0, is_good, len};
        end else if (tcnt == T_LAST) begin
          push      = 1'b1;
          push_word = {1'b1, 1'b0, len};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state       <= DISABLED;
      recv_enable <= 1'b0;
      len         <= '0;
      tcnt        <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      unique case (state)
        DISABLED: begin
          if (cfg_rx_en && !full) begin
            state       <= ARMED;
            recv_enable <= 1'b1;
          end
        end
        ARMED: begin
          // A starting frame wins over a late disable or full FIFO.
          if (receiving_frame) begin
            state       <= FRAME;
            recv_enable <= 1'b0;
            len         <= len_acc;
          end else if (!cfg_rx_en || full) begin
            state       <= DISABLED;
            recv_enable <= 1'b0;
          end
        end
        FRAME: begin
          if (verdict) begin
            state <= POST;
          end else if (!receiving_frame) begin
            state <= WAIT_RES;
            tcnt  <= '0;
          end else begin
            len <= len_acc;
          end
        end
        WAIT_RES: begin
          if (push) state <= POST;
          else      tcnt  <= tcnt + TW'(1);
        end
        POST: begin
          len <= '0;
          if (!receiving_frame) begin
            if (cfg_rx_en && !full) begin
              state       <= ARMED;
              recv_enable <= 1'b1;
            end else begin
              state <= DISABLED;
            end
          end
        end
        default: begin
          state       <= DISABLED;
          recv_enable <= 1'b0;
        end
      endcase
      if (push) begin
        if (push_word[LEN_W]) begin
          if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
        end else begin
          if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stat_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      stat_level <= stat_level + (AW+1)'(1);
      else if (pop && !push) stat_level <= stat_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge rxclk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

endmodule
